fifo_packet_unloader: RTL and testbench
=======================================

Name: fifo_packet_unloader

Overview:
- Sits directly downstream of the switch's synchronous buffer FIFO, in non-fall-through mode.
- Drains length-prefixed packets from the FIFO and presents them on a valid/ready stream with an end-of-packet marker. The egress path then consumes that stream.
- Each packet in the FIFO is one header word followed by N payload words. The header is consumed internally and is not forwarded.

Parameters:
- DATA_WIDTH, 16, width of FIFO words and stream data.
- LENGTH_WIDTH, 12, number of header LSBs that hold the payload word count N; must be ≤ DATA_WIDTH.
- MAX_PAYLOAD_WORDS, 1024, largest legal N.
- BUFFER_DEPTH, 3, output skid-buffer entries; must be ≥ 3 to sustain 1 word/cycle.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  reset, active-low.
- fifo_read_enable  output  1  read strobe to the FIFO.
- fifo_read_data  input  DATA_WIDTH  FIFO read data.
- fifo_read_data_valid  input  1  FIFO read-data valid.
- fifo_empty  input  1  FIFO empty flag.
- m_data  output  DATA_WIDTH  stream payload word.
- m_valid  output  1  stream word valid.
- m_last  output  1  marks the final payload word of a packet.
- m_ready  input  1  downstream accept.
- length_error  output  1  one-cycle pulse when a header is rejected.
- packet_count  output  16  packets fully emitted; wraps at 2^16.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is named clock; reset port is named reset_n.
- Reset (also mid-packet): asynchronous, immediate. Clears state to IDLE, empties the buffer, clears inflight and counters. All outputs are 0. A partially emitted packet is abandoned with no m_last.

FIFO read contract:
- A read issued in cycle t returns data in cycle t+1.
- fifo_read_data_valid is sticky in the FIFO. Sample fifo_read_data only in the cycle after this block asserted fifo_read_enable (inflight=1), qualified by fifo_read_data_valid. Ignore it otherwise.
- Never assert fifo_read_enable while fifo_empty=1.
- At most one read is in flight.

State machine: IDLE, HEADER, PAYLOAD.
- IDLE:
  - fifo_empty=0 → assert fifo_read_enable for one cycle (header read); go to HEADER.
- HEADER:
  - Wait for the inflight sample.
  - Let N = header[LENGTH_WIDTH-1:0]; upper header bits are ignored.
  - N=0 or N>MAX_PAYLOAD_WORDS → length_error=1 for one cycle; go to IDLE. No payload words are read or dropped.
  - Otherwise load remaining_reads=N and remaining_emits=N; go to PAYLOAD.
- PAYLOAD:
  - Assert fifo_read_enable when all of these hold: remaining_reads>0, fifo_empty=0, and (buffered + inflight − pop) < BUFFER_DEPTH, where pop = m_valid&&m_ready.
  - Each read decrements remaining_reads. Reads never cross into the next packet's header.
  - Each sampled word is pushed into the buffer tail.
  - Each pop decrements remaining_emits.
  - When the pop of the word with remaining_emits=1 occurs → packet_count+1; go to IDLE.
  - The next header read may be issued in the following cycle.

Output buffer:
- FIFO order.
- m_valid = buffer non-empty; m_data = head entry.
- m_last = 1 when the head entry is the Nth word (tagged on push).
- Push and pop may occur in the same cycle. Count is unchanged; data order is preserved.
- m_data, m_valid and m_last are held stable while m_valid=1 and m_ready=0.

Latency and throughput:
- Header read_enable in cycle 0 → header sampled in cycle 1 → PAYLOAD and first payload read in cycle 2 → sample in cycle 3 → m_valid=1 in cycle 4.
- Steady state with m_ready=1 and the FIFO non-empty: one payload word per cycle.

FIFO empty mid-packet:
- Reads stall and the buffer drains; m_valid drops once it is empty.
- Reads resume when fifo_empty deasserts.

Arithmetic:
- Counters are LENGTH_WIDTH+1 bits.
- packet_count is modulo 2^16.

Test Plan:
- Single packet: FIFO holds header 0x0003 then 0xA1, 0xA2, 0xA3; m_ready=1 → m_valid in cycles 4, 5, 6 with data 0xA1/0xA2/0xA3; m_last only on 0xA3; packet_count=1; exactly 4 read strobes.
- Backpressure: header 0x0005 plus 5 words; m_ready toggles 1,0,0,1,… → no word lost or duplicated; data stable while stalled; at most 3 words buffered; no fifo_read_enable when full; m_last on the 5th word.
- Back-to-back packets: headers 2 and 1 queued with their payloads → the second header is not read until remaining_reads=0; two m_last pulses; packet_count=2.
- Bad length: header 0x0000, then header 0x0401 (N=1025) → two length_error pulses; no m_valid; state returns to IDLE each time; packet_count=0.
- Empty mid-packet: header 4 with only 2 words present, the rest written 10 cycles later → m_valid gaps with no spurious words; fifo_read_enable never asserted while fifo_empty=1; completes with m_last on the 4th word.
- Reset mid-packet: assert reset_n=0 after 2 of 6 words are emitted → all outputs 0 immediately; after release, the next header is processed normally.

Source files
------------

// File: rtl/fifo_packet_unloader.sv
// Drains length-prefixed packets from a non-fall-through FIFO onto a valid/ready
// stream. The header word is consumed internally and the final payload word is flagged.
module fifo_packet_unloader #(
  parameter int DATA_WIDTH        = 16,
  parameter int LENGTH_WIDTH      = 12,
  parameter int MAX_PAYLOAD_WORDS = 1024,
  parameter int BUFFER_DEPTH      = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_read_data_valid,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  length_error,
  output logic [15:0]           packet_count
);

  localparam int CNT_W = LENGTH_WIDTH + 1;
  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

  state_t                r_state;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [CNT_W-1:0]      r_remaining_reads;
  logic [CNT_W-1:0]      r_remaining_emits;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [OCC_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_buf_data [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] r_buf_last;
  logic                  r_length_error;
  logic [15:0]           r_packet_count;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_sample;
  logic                  w_stall;
  logic                  w_push;
  logic                  w_room;
  logic                  w_hdr_bad;
  logic                  w_read;
  logic [CNT_W-1:0]      w_hdr_len;
  logic [OCC_W:0]        w_occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & m_ready;
  assign w_sample = r_inflight & fifo_read_data_valid;
  assign w_stall  = r_inflight & ~fifo_read_data_valid;
  assign w_push   = w_sample & (r_state == S_PAYLOAD);

  assign w_hdr_len = CNT_W'(fifo_read_data[LENGTH_WIDTH-1:0]);
  assign w_hdr_bad = (w_hdr_len == '0) || (w_hdr_len > CNT_W'(MAX_PAYLOAD_WORDS));

  // Words already buffered plus the one in flight, less the one leaving this cycle.
  assign w_occupancy = (OCC_W+1)'(r_count) + (OCC_W+1)'(r_inflight) - (OCC_W+1)'(w_pop);
  assign w_room      = (w_occupancy < (OCC_W+1)'(BUFFER_DEPTH));

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    w_read = 1'b0;
    case (r_state)
      S_IDLE:    w_read = ~fifo_empty;
      S_PAYLOAD: w_read = (r_remaining_reads != '0) && !fifo_empty && !w_stall && w_room;
      default:   w_read = 1'b0;
    endcase
  end

  // The read strobe must follow fifo_empty within the cycle, so it cannot be registered.
  assign fifo_read_enable = w_read & reset_n;
  assign m_valid          = w_valid;
  assign m_data           = w_valid ? r_buf_data[r_head] : '0;
  assign m_last           = w_valid & r_buf_last[r_head];
  assign length_error     = r_length_error;
  assign packet_count     = r_packet_count;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_inflight        <= 1'b0;
      r_inflight_last   <= 1'b0;
      r_remaining_reads <= '0;
      r_remaining_emits <= '0;
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_length_error    <= 1'b0;
      r_packet_count    <= '0;
    end else begin
      r_length_error <= 1'b0;
      r_inflight     <= w_read | w_stall;
      if (w_read) begin
        r_inflight_last <= (r_remaining_reads == CNT_W'(1)) && (r_state == S_PAYLOAD);
      end

      case (r_state)
        S_IDLE: begin
          if (w_read) r_state <= S_HEADER;
        end
        S_HEADER: begin
          if (w_sample) begin
            if (w_hdr_bad) begin
              r_length_error <= 1'b1;
              r_state        <= S_IDLE;
            end else begin
              r_remaining_reads <= w_hdr_len;
              r_remaining_emits <= w_hdr_len;
              r_state           <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_read) r_remaining_reads <= r_remaining_reads - CNT_W'(1);
          if (w_pop) begin
            r_remaining_emits <= r_remaining_emits - CNT_W'(1);
            if (r_remaining_emits == CNT_W'(1)) begin
              r_packet_count <= r_packet_count + 16'd1;
              r_state        <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  // NOTE: buffer storage is deliberately not reset; r_count gates every read of it,
  // and m_data/m_last are forced to 0 while the buffer is empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_buf_data[r_tail] <= fifo_read_data;
      r_buf_last[r_tail] <= r_inflight_last;
    end
  end

endmodule

// File: tb/tb_fifo_packet_unloader.sv
// Directed bench for fifo_packet_unloader: a behavioural non-fall-through FIFO
// feeds the DUT and the stream side is captured and compared to hand-computed values.
module tb_fifo_packet_unloader;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_data = '0;
  logic          fifo_read_data_valid = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          length_error;
  logic [15:0]   packet_count;

  fifo_packet_unloader dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .fifo_read_enable     (fifo_read_enable),
    .fifo_read_data       (fifo_read_data),
    .fifo_read_data_valid (fifo_read_data_valid),
    .fifo_empty           (fifo_empty),
    .m_data               (m_data),
    .m_valid              (m_valid),
    .m_last               (m_last),
    .m_ready              (m_ready),
    .length_error         (length_error),
    .packet_count         (packet_count)
  );

  always #5 clock = ~clock;

  // Synchronous FIFO model: data one cycle after the strobe, valid stays high.
  logic [DW-1:0] fifo_mem [256];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_flush = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read_enable && !fifo_empty) begin
      fifo_read_data       <= fifo_mem[rd_ptr[7:0]];
      fifo_read_data_valid <= 1'b1;
      rd_ptr               <= rd_ptr + 1;
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] cap [$];
  int          strobe_cnt, pop_cnt, max_out, cyc_idx;
  int          rd_empty_viol = 0;
  int          stall_viol = 0;
  logic [31:0] vmask, emask;
  logic        prev_stall;
  logic [16:0] prev_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cap.delete();
    strobe_cnt = 0;
    pop_cnt    = 0;
    max_out    = 0;
    cyc_idx    = 0;
    vmask      = '0;
    emask      = '0;
    prev_stall = 1'b0;
    prev_word  = '0;
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  function automatic logic [16:0] cap_at(input int i);
    return (i < cap.size()) ? cap[i] : 17'h1FFFF;
  endfunction

  // One clock: drive m_ready, observe at the falling edge, return just after the rising edge.
  task automatic cycle(input logic rdy);
    m_ready = rdy;
    @(negedge clock);
    if (fifo_read_enable) strobe_cnt++;
    if (fifo_read_enable && fifo_empty) rd_empty_viol++;
    if (prev_stall && (!m_valid || {m_last, m_data} != prev_word)) stall_viol++;
    prev_stall = m_valid && !m_ready;
    prev_word  = {m_last, m_data};
    if (m_valid && m_ready) begin
      cap.push_back({m_last, m_data});
      pop_cnt++;
    end
    if (cyc_idx < 32) begin
      vmask[cyc_idx] = m_valid;
      emask[cyc_idx] = length_error;
    end
    if (strobe_cnt - pop_cnt > max_out) max_out = strobe_cnt - pop_cnt;
    cyc_idx++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clock);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_length_error", length_error, 0);
    check("rst_packet_count", packet_count, 0);
    check("rst_read_enable", fifo_read_enable, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single packet of three words.
    clear_stats();
    fifo_write(16'h0003); fifo_write(16'h00A1); fifo_write(16'h00A2); fifo_write(16'h00A3);
    for (int k = 0; k < 10; k++) cycle(1'b1);
    check("single_valid_cycles", vmask[9:0], 10'h070);
    check("single_w0", cap_at(0), 17'h000A1);
    check("single_w1", cap_at(1), 17'h000A2);
    check("single_w2_last", cap_at(2), 17'h100A3);
    check("single_strobes", strobe_cnt, 4);
    check("single_pkt_count", packet_count, 1);

    // Backpressure: m_ready high one cycle in three.
    clear_stats();
    fifo_write(16'h0005);
    for (int i = 1; i <= 5; i++) fifo_write(16'h00B0 + 16'(i));
    for (int k = 0; k < 40; k++) cycle(k % 3 == 0);
    check("bp_word_count", cap.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("bp_w%0d", i), cap_at(i), {(i == 4), 16'h00B1 + 16'(i)});
    check("bp_max_buffered", max_out - 1, 3);
    check("bp_stall_stable", stall_viol, 0);
    check("bp_pkt_count", packet_count, 2);

    // Back-to-back packets of 2 and 1 words.
    clear_stats();
    fifo_write(16'h0002); fifo_write(16'h00C1); fifo_write(16'h00C2);
    fifo_write(16'h0001); fifo_write(16'h00D1);
    for (int k = 0; k < 14; k++) cycle(1'b1);
    check("b2b_valid_cycles", vmask[13:0], 14'h0430);
    check("b2b_w0", cap_at(0), 17'h000C1);
    check("b2b_w1_last", cap_at(1), 17'h100C2);
    check("b2b_w2_last", cap_at(2), 17'h100D1);
    check("b2b_strobes", strobe_cnt, 5);
    check("b2b_pkt_count", packet_count, 4);

    // Rejected headers: N=0 and N=1025.
    clear_stats();
    fifo_write(16'h0000); fifo_write(16'h0401);
    for (int k = 0; k < 8; k++) cycle(1'b1);
    check("badlen_error_cycles", emask[7:0], 8'h14);
    check("badlen_no_valid", vmask[7:0], 8'h00);
    check("badlen_strobes", strobe_cnt, 2);
    check("badlen_pkt_count", packet_count, 4);

    // Upper header bits are ignored: 0xF001 is a one-word packet.
    clear_stats();
    fifo_write(16'hF001); fifo_write(16'h00E1);
    for (int k = 0; k < 8; k++) cycle(1'b1);
    check("hibits_word_count", cap.size(), 1);
    check("hibits_w0_last", cap_at(0), 17'h100E1);
    check("hibits_pkt_count", packet_count, 5);

    // FIFO runs empty mid-packet.
    clear_stats();
    fifo_write(16'h0004); fifo_write(16'h00F1); fifo_write(16'h00F2);
    for (int k = 0; k < 10; k++) cycle(1'b1);
    check("empty_valid_cycles", vmask[9:0], 10'h030);
    check("empty_partial_count", cap.size(), 2);
    fifo_write(16'h00F3); fifo_write(16'h00F4);
    for (int k = 0; k < 12; k++) cycle(1'b1);
    check("empty_word_count", cap.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("empty_w%0d", i), cap_at(i), {(i == 3), 16'h00F1 + 16'(i)});
    check("empty_pkt_count", packet_count, 6);

    // Reset after two of six words have been emitted.
    clear_stats();
    fifo_write(16'h0006);
    for (int i = 1; i <= 6; i++) fifo_write(16'h0070 + 16'(i));
    for (int k = 0; k < 6; k++) cycle(1'b1);
    check("midrst_emitted", cap.size(), 2);
    reset_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_read_enable", fifo_read_enable, 0);
    check("midrst_length_error", length_error, 0);
    check("midrst_pkt_count", packet_count, 0);
    fifo_flush = 1'b1;
    @(posedge clock);
    #1;
    fifo_flush = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_stats();
    fifo_write(16'h0001); fifo_write(16'h0081);
    for (int k = 0; k < 8; k++) cycle(1'b1);
    check("postrst_word_count", cap.size(), 1);
    check("postrst_w0_last", cap_at(0), 17'h10081);
    check("postrst_pkt_count", packet_count, 1);

    check("read_while_empty", rd_empty_viol, 0);
    check("stall_stable_all", stall_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
